// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the 7-segment scan driver: value/control in, anode/cathode drive out.
// The driver connects through the slave modport, the value source through master.
interface seg7_scan_driver_if;
    logic [31:0] data_i;
    logic        hold_i;
    logic        blank_lz_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    modport master (
        output data_i, hold_i, blank_lz_i,
        input  an_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  data_i, hold_i, blank_lz_i,
        output an_o, seg_o, dp_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit value onto an 8-digit multiplexed 7-segment display as hex nibbles,
// capturing the value once per frame with optional hold and leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      shown;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic             frame_q;

    logic             tick;
    logic             boundary;
    logic             blank;
    logic [31:0]      upper;
    logic [3:0]       nib;
    logic [6:0]       enc;

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        boundary = tick && (idx == 3'd7);
        // upper holds shown[31:4*idx] right-aligned: its low nibble is the digit,
        // and it being zero means this digit and all above it are leading zeros
        upper    = shown >> {idx, 2'b00};
        nib      = upper[3:0];
        blank    = bus.blank_lz_i && (idx != 3'd0) && (upper == '0);
        enc      = '1;
        unique case (nib)
            4'h0: enc = 7'h40;
            4'h1: enc = 7'h79;
            4'h2: enc = 7'h24;
            4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;
            4'h5: enc = 7'h12;
            4'h6: enc = 7'h02;
            4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;
            4'h9: enc = 7'h10;
            4'hA: enc = 7'h08;
            4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;
            4'hD: enc = 7'h21;
            4'hE: enc = 7'h06;
            4'hF: enc = 7'h0E;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            idx     <= '0;
            shown   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            frame_q <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            if (boundary && !bus.hold_i) begin
                shown <= bus.data_i;
            end
            frame_q <= boundary;
            an_q    <= blank ? '1 : ~(8'b1 << idx);
            seg_q   <= blank ? '1 : enc;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = 1'b1;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a REFRESH_DIV=4 instance for scanning/capture/hold/blanking,
// and a REFRESH_DIV=1 instance for the mid-frame reset case.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus_a ();
    seg7_scan_driver_if bus_b ();

    seg7_scan_driver #(.REFRESH_DIV(4)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a.slave)
    );

    seg7_scan_driver #(.REFRESH_DIV(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [31:0]     data;
        logic            blank_lz;
        logic [7:0]      blk;   // digits expected to be blanked
        logic [7:0][6:0] seg;   // expected cathodes, index = digit
    } vec_t;

    vec_t vecs [9];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Steps until frame_o is seen high (at most limit cycles); n = cycles taken, 0 on timeout
    task automatic wait_frame(input bit use_b, input int limit, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if ((use_b ? bus_b.frame_o : bus_a.frame_o) === 1'b1) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_o within %0d cycles expected pulse", limit);
        end
    endtask

    task automatic check_digit(input string name, input int d, input logic [6:0] seg_exp);
        logic [7:0] an_exp;
        an_exp = ~(8'b1 << d);
        check({name, "_an"}, bus_a.an_o, an_exp);
        check({name, "_seg"}, bus_a.seg_o, seg_exp);
    endtask

    initial begin
        int n;

        vecs[0] = '{32'h1234ABCD, 1'b0, 8'b0000_0000,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[1] = '{32'hFFFF0000, 1'b0, 8'b0000_0000,
                    {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[2] = '{32'h00000050, 1'b1, 8'b1111_1100,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[3] = '{32'h00000000, 1'b1, 8'b1111_1110,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{32'h76543210, 1'b0, 8'b0000_0000,
                    {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};
        vecs[5] = '{32'h89ABCDEF, 1'b0, 8'b0000_0000,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[6] = '{32'h00F00000, 1'b1, 8'b1100_0000,
                    {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[7] = '{32'h00F00000, 1'b0, 8'b0000_0000,
                    {7'h40, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{32'h80000000, 1'b1, 8'b0000_0000,
                    {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.data_i = '0;
        bus_a.hold_i = 1'b0;
        bus_a.blank_lz_i = 1'b0;
        bus_b.data_i = 32'hCAFE1234;
        bus_b.hold_i = 1'b0;
        bus_b.blank_lz_i = 1'b0;

        // Reset and basic scan timing
        step(3);
        check("rst_an", bus_a.an_o, 8'hFF);
        check("rst_seg", bus_a.seg_o, 7'h7F);
        check("rst_dp", bus_a.dp_o, 1'b1);
        check("rst_frame", bus_a.frame_o, 1'b0);
        rst_a = 1'b0;
        step(1);
        check("first_an", bus_a.an_o, 8'hFE);
        check("first_seg", bus_a.seg_o, 7'h40);
        step(3);
        check("dwell_an", bus_a.an_o, 8'hFE);
        step(1);
        check("dwell_next_an", bus_a.an_o, 8'hFD);
        for (int d = 2; d < 8; d++) begin
            step(4);
            check_digit("scan", d, 7'h40);
        end
        wait_frame(1'b0, 40, n);
        check("first_frame_cycles", n, 3);
        check("frame_edge_an", bus_a.an_o, 8'h7F);
        wait_frame(1'b0, 40, n);
        check("frame_period", n, 32);
        step(1);
        check("frame_width", bus_a.frame_o, 1'b0);
        check("after_frame_an", bus_a.an_o, 8'hFE);

        // Table-driven frames: capture value, then verify every digit slot of the next frame
        foreach (vecs[v]) begin
            bus_a.data_i = vecs[v].data;
            bus_a.blank_lz_i = vecs[v].blank_lz;
            wait_frame(1'b0, 40, n);
            step(1);
            for (int d = 0; d < 8; d++) begin
                if (vecs[v].blk[d]) begin
                    check("vec_an_blank", bus_a.an_o, 8'hFF);
                    check("vec_seg_blank", bus_a.seg_o, 7'h7F);
                end else begin
                    check_digit("vec", d, vecs[v].seg[d]);
                end
                if (d < 7) step(4);
            end
        end

        // Mid-frame data change stays invisible until the next capture
        bus_a.data_i = 32'h1234ABCD;
        bus_a.blank_lz_i = 1'b0;
        wait_frame(1'b0, 40, n);
        step(1);
        check_digit("mid_d0", 0, 7'h21);
        step(8);
        check_digit("mid_d2", 2, 7'h03);
        bus_a.data_i = 32'hFFFF0000;
        step(4);
        check_digit("mid_d3_old", 3, 7'h08);
        step(4);
        check_digit("mid_d4_old", 4, 7'h19);
        wait_frame(1'b0, 40, n);
        step(1);
        check_digit("mid_d0_new", 0, 7'h40);
        step(16);
        check_digit("mid_d4_new", 4, 7'h0E);

        // Hold keeps the captured value but frame_o still pulses
        bus_a.hold_i = 1'b1;
        bus_a.data_i = 32'h12345678;
        wait_frame(1'b0, 40, n);
        check("hold_frame_cycles", n, 15);
        step(1);
        check("hold_frame_width", bus_a.frame_o, 1'b0);
        check_digit("hold_d0", 0, 7'h40);
        step(28);
        check_digit("hold_d7", 7, 7'h0E);
        bus_a.hold_i = 1'b0;
        wait_frame(1'b0, 40, n);
        step(1);
        check_digit("release_d0", 0, 7'h00);
        step(28);
        check_digit("release_d7", 7, 7'h79);

        // REFRESH_DIV=1: reset pulsed while idx=5 restarts the scan with shown=0
        check("b_held_an", bus_b.an_o, 8'hFF);
        rst_b = 1'b0;
        wait_frame(1'b1, 20, n);
        check("b_frame_cycles", n, 8);
        step(5);
        check("b_mid_an", bus_b.an_o, 8'hEF);
        check("b_mid_seg", bus_b.seg_o, 7'h06);
        rst_b = 1'b1;
        step(1);
        check("b_rst_an", bus_b.an_o, 8'hFF);
        check("b_rst_seg", bus_b.seg_o, 7'h7F);
        check("b_rst_frame", bus_b.frame_o, 1'b0);
        rst_b = 1'b0;
        step(1);
        check("b_restart_an", bus_b.an_o, 8'hFE);
        check("b_restart_seg", bus_b.seg_o, 7'h40);
        step(1);
        check("b_restart_d1_an", bus_b.an_o, 8'hFD);
        check("b_restart_d1_seg", bus_b.seg_o, 7'h40);
        wait_frame(1'b1, 20, n);
        check("b_restart_frame", n, 6);
        step(1);
        check("b_new_an", bus_b.an_o, 8'hFE);
        check("b_new_seg", bus_b.seg_o, 7'h19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
